// File: rtl/irq_controller_if.sv
// Peripheral bus and CPU interrupt handshake bundle for the D16i interrupt controller.
interface irq_controller_if;
    logic [15:0] din;
    logic [15:0] addr;
    logic        we;
    logic [15:0] dout;
    logic        cpu_irq;
    logic        cpu_ack;
    logic [15:0] vector;

    modport master (
        output din, addr, we, cpu_ack,
        input  dout, cpu_irq, vector
    );

    modport slave (
        input  din, addr, we, cpu_ack,
        output dout, cpu_irq, vector
    );
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: latches/masks NUM_IRQ sources, requests the CPU,
// hands out BASE+index on acknowledge and holds the source in service until EOI.
module irq_controller #(
    parameter int unsigned NUM_IRQ = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    irq_controller_if.slave      bus,
    input  logic [NUM_IRQ-1:0]   irq_in
);

    typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

    state_e               state_q, state_d;
    logic [NUM_IRQ-1:0]   edge_pend_q, edge_pend_d;
    logic [NUM_IRQ-1:0]   enable_q, enable_d;
    logic [NUM_IRQ-1:0]   edge_sel_q, edge_sel_d;
    logic [NUM_IRQ-1:0]   in_service_q, in_service_d;
    logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
    logic [15:0]          vbase_q, vbase_d;
    logic [15:0]          vector_q, vector_d;

    logic [3:0]           reg_addr;
    logic                 wr_pend, wr_en, wr_sel, wr_base, wr_eoi;
    logic [NUM_IRQ-1:0]   pending, active, rise, w1c, ack_clr;
    logic [NUM_IRQ-1:0]   win_onehot;
    logic [3:0]           win_idx;

    assign reg_addr = bus.addr[3:0];
    assign wr_pend  = bus.we && (reg_addr == 4'h0);
    assign wr_en    = bus.we && (reg_addr == 4'h1);
    assign wr_sel   = bus.we && (reg_addr == 4'h2);
    assign wr_base  = bus.we && (reg_addr == 4'h3);
    assign wr_eoi   = bus.we && (reg_addr == 4'h5);

    // Edge-mode bits come from the latched flops, level-mode bits follow the line directly.
    assign pending = (edge_pend_q & edge_sel_q) | (irq_in & ~edge_sel_q);
    assign active  = pending & enable_q;
    assign rise    = irq_in & ~irq_prev_q;
    assign w1c     = wr_pend ? bus.din[NUM_IRQ-1:0] : '0;

    // Lowest set index wins; scanning downward leaves the lowest one last.
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_idx       = 4'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        in_service_d = in_service_q;
        vector_d     = vector_q;
        ack_clr      = '0;
        unique case (state_q)
            StIdle: begin
                if (|active) state_d = StReq;
            end
            StReq: begin
                if (!(|active)) begin
                    state_d = StIdle;
                end else if (bus.cpu_ack) begin
                    vector_d     = vbase_q + 16'(win_idx);
                    in_service_d = win_onehot;
                    ack_clr      = win_onehot;
                    state_d      = StService;
                end
            end
            StService: begin
                if (wr_eoi) begin
                    in_service_d = '0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        enable_d   = wr_en   ? bus.din[NUM_IRQ-1:0] : enable_q;
        edge_sel_d = wr_sel  ? bus.din[NUM_IRQ-1:0] : edge_sel_q;
        vbase_d    = wr_base ? bus.din : vbase_q;
        irq_prev_d = irq_in;
        // A fresh edge beats any clear; switching a bit to level drops its stale latch.
        edge_pend_d = ((edge_pend_q & ~(w1c | ack_clr)) | (rise & edge_sel_q)) & edge_sel_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            edge_pend_q  <= '0;
            enable_q     <= '0;
            edge_sel_q   <= '0;
            in_service_q <= '0;
            irq_prev_q   <= '0;
            vbase_q      <= '0;
            vector_q     <= '0;
        end else begin
            state_q      <= state_d;
            edge_pend_q  <= edge_pend_d;
            enable_q     <= enable_d;
            edge_sel_q   <= edge_sel_d;
            in_service_q <= in_service_d;
            irq_prev_q   <= irq_prev_d;
            vbase_q      <= vbase_d;
            vector_q     <= vector_d;
        end
    end

    always_comb begin
        bus.dout = '0;
        case (reg_addr)
            4'h0:    bus.dout = 16'(pending);
            4'h1:    bus.dout = 16'(enable_q);
            4'h2:    bus.dout = 16'(edge_sel_q);
            4'h3:    bus.dout = vbase_q;
            4'h4:    bus.dout = 16'(in_service_q);
            default: bus.dout = '0;
        endcase
    end

    assign bus.cpu_irq = (state_q == StReq);
    assign bus.vector  = vector_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: directed scenarios followed by random traffic,
// all checked against a behavioural model of the register/request rules.
module tb_irq_controller;

    localparam int N = 8;
    localparam logic [15:0] MASK = 16'((1 << N) - 1);

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_in;

    irq_controller_if bus();

    irq_controller #(.NUM_IRQ(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .irq_in (irq_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic [15:0] dout;
        logic [15:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state.
    logic [15:0] m_epend, m_en, m_es, m_base, m_vec, m_prev;
    int          m_isr;
    int          m_phase;  // 0 quiet, 1 requesting, 2 serving

    logic [N-1:0] irq_cur;
    logic         rst_cur;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_epend = '0; m_en = '0; m_es = '0; m_base = '0; m_vec = '0; m_prev = '0;
        m_isr = -1;
        m_phase = 0;
    endtask

    function automatic logic [15:0] m_pending(input logic [15:0] irq);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i] = m_es[i] ? m_epend[i] : irq[i];
        return p;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a, input logic [15:0] irq);
        case (a[3:0])
            4'h0:    return m_pending(irq);
            4'h1:    return m_en;
            4'h2:    return m_es;
            4'h3:    return m_base;
            4'h4:    return (m_isr >= 0) ? (16'd1 << m_isr) : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [15:0] a, input logic [15:0] d,
                              input logic [15:0] irq, input logic ack);
        logic [15:0] act, es_old;
        int w;
        act    = m_pending(irq) & m_en;
        es_old = m_es;
        if (m_phase == 0) begin
            if (act != 0) m_phase = 1;
        end else if (m_phase == 1) begin
            if (act == 0) begin
                m_phase = 0;
            end else if (ack) begin
                w = -1;
                for (int i = 0; i < N; i++) if (act[i] && w < 0) w = i;
                m_vec      = m_base + 16'(w);
                m_isr      = w;
                m_epend[w] = 1'b0;
                m_phase    = 2;
            end
        end else if (we && a[3:0] == 4'h5) begin
            m_isr   = -1;
            m_phase = 0;
        end
        if (we) begin
            case (a[3:0])
                4'h0: m_epend = m_epend & ~d;
                4'h1: m_en    = d & MASK;
                4'h2: m_es    = d & MASK;
                4'h3: m_base  = d;
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            if (es_old[i] && irq[i] && !m_prev[i]) m_epend[i] = 1'b1;
            if (!m_es[i]) m_epend[i] = 1'b0;
        end
        m_prev = irq;
    endtask

    task automatic drive(input logic we, input logic [15:0] a, input logic [15:0] d,
                         input logic ack);
        exp_t e;
        bus.we      = we;
        bus.addr    = a;
        bus.din     = d;
        bus.cpu_ack = ack;
        irq_in      = irq_cur;
        rst         = rst_cur;
        if (rst_cur) model_reset();
        e.irq  = (m_phase == 1);
        e.dout = m_read(a, 16'(irq_cur));
        e.vec  = m_vec;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_step(bus.we, bus.addr, bus.din, 16'(irq_in), bus.cpu_ack);
        #1;
    endtask

    task automatic cyc(input logic we, input logic [15:0] a, input logic [15:0] d,
                       input logic ack);
        drive(we, a, d, ack);
        tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 16'($urandom_range(0, 7)), 16'h0, 1'b0);
    endtask

    task automatic ack();
        cyc(1'b0, 16'h4, 16'h0, 1'b1);
    endtask

    task automatic read_chk(input string name, input logic [15:0] a, input logic [15:0] exp);
        drive(1'b0, a, 16'h0, 1'b0);
        #1;
        check(name, bus.dout, exp);
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_cpu_irq", {15'b0, bus.cpu_irq}, {15'b0, e.irq});
            check("sb_dout", bus.dout, e.dout);
            check("sb_vector", bus.vector, e.vec);
        end
    end

    initial begin
        logic [N-1:0] flip;
        rst_cur = 1'b1;
        irq_cur = '0;
        model_reset();
        bus.we = 1'b0; bus.addr = '0; bus.din = '0; bus.cpu_ack = 1'b0;
        irq_in = '0; rst = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b0, 16'h0, 16'h0, 1'b0);
        rst_cur = 1'b0;
        read_chk("rst_enable", 16'h1, 16'h0000);
        read_chk("rst_base", 16'h3, 16'h0000);

        // Single edge source through a full request/ack/EOI round trip.
        wr(16'h1, 16'h0001);
        wr(16'h2, 16'h0001);
        wr(16'h3, 16'h0100);
        irq_cur = 8'h01;
        idle(1);
        check("t1_irq_not_yet", {15'b0, bus.cpu_irq}, 16'h0);
        irq_cur = 8'h00;
        read_chk("t1_pending", 16'h0, 16'h0001);
        check("t1_irq_up", {15'b0, bus.cpu_irq}, 16'h1);
        ack();
        check("t1_vector", bus.vector, 16'h0100);
        check("t1_irq_down", {15'b0, bus.cpu_irq}, 16'h0);
        read_chk("t1_isr", 16'h4, 16'h0001);
        read_chk("t1_pend_clr", 16'h0, 16'h0000);
        wr(16'h5, 16'hBEEF);
        read_chk("t1_isr_eoi", 16'h4, 16'h0000);

        // Two simultaneous edges: lower index first.
        wr(16'h1, 16'h00FF);
        wr(16'h2, 16'h00FF);
        wr(16'h3, 16'h0040);
        irq_cur = 8'h24;
        idle(1);
        irq_cur = 8'h00;
        idle(1);
        ack();
        check("t2_vec_first", bus.vector, 16'h0042);
        wr(16'h5, 16'h0);
        idle(1);
        check("t2_rereq", {15'b0, bus.cpu_irq}, 16'h1);
        ack();
        check("t2_vec_second", bus.vector, 16'h0045);
        wr(16'h5, 16'h0);

        // Level source held, then dropped while requesting.
        wr(16'h2, 16'h0000);
        wr(16'h1, 16'h0008);
        irq_cur = 8'h08;
        idle(1);
        check("t3_req", {15'b0, bus.cpu_irq}, 16'h1);
        ack();
        check("t3_vec", bus.vector, 16'h0043);
        wr(16'h5, 16'h0);
        idle(1);
        check("t3_rereq", {15'b0, bus.cpu_irq}, 16'h1);
        irq_cur = 8'h00;
        idle(1);
        check("t3_drop", {15'b0, bus.cpu_irq}, 16'h0);

        // Masked edge still records, unmask requests, W1C withdraws.
        wr(16'h1, 16'h0000);
        wr(16'h2, 16'h0002);
        irq_cur = 8'h02;
        idle(1);
        irq_cur = 8'h00;
        read_chk("t4_pend_masked", 16'h0, 16'h0002);
        idle(2);
        check("t4_no_req", {15'b0, bus.cpu_irq}, 16'h0);
        wr(16'h1, 16'h0002);
        idle(1);
        check("t4_req", {15'b0, bus.cpu_irq}, 16'h1);
        wr(16'h0, 16'h0002);
        idle(1);
        check("t4_w1c_drop", {15'b0, bus.cpu_irq}, 16'h0);

        // New edge on the acked source in the ack cycle survives.
        wr(16'h1, 16'h0001);
        wr(16'h2, 16'h0001);
        irq_cur = 8'h01;
        idle(1);
        irq_cur = 8'h00;
        idle(1);
        irq_cur = 8'h01;
        ack();
        check("t5_vec", bus.vector, 16'h0040);
        irq_cur = 8'h00;
        read_chk("t5_pend_kept", 16'h0, 16'h0001);
        wr(16'h5, 16'h0);
        idle(1);
        check("t5_rereq", {15'b0, bus.cpu_irq}, 16'h1);
        ack();

        // Asynchronous reset while in service.
        rst_cur = 1'b1;
        drive(1'b0, 16'h4, 16'h0, 1'b1);
        #1;
        check("t6_rst_irq", {15'b0, bus.cpu_irq}, 16'h0);
        check("t6_rst_vec", bus.vector, 16'h0000);
        check("t6_rst_isr", bus.dout, 16'h0000);
        tick();
        cyc(1'b0, 16'h1, 16'h0, 1'b1);
        rst_cur = 1'b0;
        wr(16'h5, 16'h0);
        check("t6_eoi_idle_irq", {15'b0, bus.cpu_irq}, 16'h0);
        check("t6_eoi_idle_vec", bus.vector, 16'h0000);
        read_chk("t6_enable_clr", 16'h1, 16'h0000);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            flip    = N'($urandom & $urandom & $urandom);
            irq_cur = irq_cur ^ flip;
            rst_cur = ($urandom_range(0, 599) == 0);
            if ($urandom_range(0, 4) == 0)
                cyc(1'b1, 16'($urandom_range(0, 7)) | (16'($urandom) & 16'hFFF0),
                    16'($urandom), $urandom_range(0, 3) == 0);
            else
                cyc(1'b0, 16'($urandom), 16'($urandom), $urandom_range(0, 3) == 0);
        end
        rst_cur = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
